// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch redirect arbiter.
// Target width defaults to 32 bits unless the build defines ADDR_WIDTH.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_pkg;

  localparam int ADDR_WIDTH = `ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } redir_state_e;

  // Add b to a, clamping at 2^width-1 (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority encoder, lowest index wins; also reports how many requests are set.
// Purely combinational, no backpressure.
module redirect_prio_enc #(
  parameter int NUM_SRC   = 2,
  localparam int IDX_WIDTH = $clog2(NUM_SRC),
  localparam int PCW       = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0]   valid,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] winner,
  output logic [NUM_SRC-1:0]   grant,
  output logic [PCW-1:0]       pop
);

  logic found;

  always_comb begin
    any    = |valid;
    winner = '0;
    grant  = '0;
    pop    = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (valid[i]) begin
        pop = pop + PCW'(1);
        if (!found) begin
          found    = 1'b1;
          winner   = IDX_WIDTH'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/branch_redirect_arb.sv
// Age-priority redirect arbiter: oldest request wins, held target offered to fetch, younger stages flushed.
// 1-cycle request-to-redir_valid latency; an older request may replace a stalled one, others are dropped.
module branch_redirect_arb
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = branch_pkg::ADDR_WIDTH,
  parameter int NUM_SRC    = 2,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  output logic                          redir_valid,
  output logic [ADDR_WIDTH-1:0]         redir_addr,
  output logic [IDX_WIDTH-1:0]          redir_src,
  input  logic                          redir_ready,
  output logic [NUM_SRC-1:0]            flush,
  output logic [CNT_WIDTH-1:0]          accept_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);

  localparam int PCW = $clog2(NUM_SRC + 1);

  redir_state_e         state;
  logic                 any;
  logic [IDX_WIDTH-1:0] win;
  logic [NUM_SRC-1:0]   grant;
  logic [PCW-1:0]       pop;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [NUM_SRC-1:0]   younger_mask;
  logic [PCW-1:0]       drop_inc;
  logic                 accept;
  logic                 stalled;
  logic                 capture;

  redirect_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .valid  (src_valid),
    .any    (any),
    .winner (win),
    .grant  (grant),
    .pop    (pop)
  );

  assign redir_valid  = (state == PEND);
  assign accept       = (state == PEND) && redir_ready;
  assign stalled      = (state == PEND) && !redir_ready;
  // Only a strictly older source may displace a redirect fetch has not taken yet.
  assign capture      = any && (!stalled || (win < redir_src));
  // One-hot grant at w: (grant<<1)-1 covers 0..w, so its complement is w+1..top.
  assign younger_mask = ~((grant << 1) - NUM_SRC'(1));

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) win_addr = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // While stalled every request is lost: either the new ones, or all but the
  // replacing winner plus the displaced held one. Same count either way.
  always_comb begin
    drop_inc = '0;
    if (any) drop_inc = stalled ? pop : (pop - PCW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      redir_addr <= '0;
      redir_src  <= '0;
      flush      <= '0;
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      flush <= capture ? younger_mask : '0;
      if (capture) begin
        redir_addr <= win_addr;
        redir_src  <= win;
        state      <= PEND;
      end else if (accept) begin
        state <= IDLE;
      end
      if (accept) accept_cnt <= CNT_WIDTH'(sat_add(64'(accept_cnt), 64'd1, CNT_WIDTH));
      if (any)    drop_cnt   <= CNT_WIDTH'(sat_add(64'(drop_cnt), 64'(drop_inc), CNT_WIDTH));
    end
  end

endmodule

// File: tb/tb_branch_redirect_arb.sv
// Randomized and directed bench for branch_redirect_arb against a queue-based reference model.
// Two instances share stimulus: 16-bit counters and 2-bit counters for saturation.
module tb_branch_redirect_arb;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N*AW-1:0] src_addr;
  logic            redir_ready;

  logic            redir_valid, s_valid;
  logic [AW-1:0]   redir_addr, s_addr;
  logic [1:0]      redir_src, s_src;
  logic [N-1:0]    flush, s_flush;
  logic [15:0]     accept_cnt, drop_cnt;
  logic [1:0]      s_acc, s_drop;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_addr;
  int          m_src;
  logic [N-1:0] m_flush;
  int          m_acc;
  int          m_drop;

  always #5 clk = ~clk;

  branch_redirect_arb #(.ADDR_WIDTH(AW), .NUM_SRC(N), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_addr(src_addr),
    .redir_valid(redir_valid), .redir_addr(redir_addr), .redir_src(redir_src),
    .redir_ready(redir_ready), .flush(flush), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  branch_redirect_arb #(.ADDR_WIDTH(AW), .NUM_SRC(N), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_addr(src_addr),
    .redir_valid(s_valid), .redir_addr(s_addr), .redir_src(s_src),
    .redir_ready(redir_ready), .flush(s_flush), .accept_cnt(s_acc), .drop_cnt(s_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step();
    int  q[$];
    bit  was;
    bit  acc_now;
    int  w;
    for (int i = 0; i < N; i++) if (src_valid[i]) q.push_back(i);
    if (rst) begin
      m_valid = 0; m_addr = '0; m_src = 0; m_flush = '0; m_acc = 0; m_drop = 0;
      return;
    end
    was     = m_valid;
    acc_now = was && redir_ready;
    if (acc_now) m_acc++;
    m_flush = '0;
    if (q.size() > 0) begin
      w = q[0];
      if (!was || redir_ready || w < m_src) begin
        m_drop += q.size() - 1 + ((was && !redir_ready) ? 1 : 0);
        m_valid = 1;
        m_addr  = src_addr[w*AW +: AW];
        m_src   = w;
        for (int j = w + 1; j < N; j++) m_flush[j] = 1'b1;
      end else begin
        m_drop += q.size();
      end
    end else if (acc_now) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    chk("valid",   64'(redir_valid), 64'(m_valid));
    chk("addr",    64'(redir_addr),  64'(m_addr));
    chk("src",     64'(redir_src),   64'(m_src));
    chk("flush",   64'(flush),       64'(m_flush));
    chk("acc16",   64'(accept_cnt),  64'(sat(m_acc, 65535)));
    chk("drop16",  64'(drop_cnt),    64'(sat(m_drop, 65535)));
    chk("s_valid", 64'(s_valid),     64'(m_valid));
    chk("s_flush", 64'(s_flush),     64'(m_flush));
    chk("acc2",    64'(s_acc),       64'(sat(m_acc, 3)));
    chk("drop2",   64'(s_drop),      64'(sat(m_drop, 3)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_addr(input int i, input logic [31:0] a);
    src_addr[i*AW +: AW] = a;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_addr = '0; redir_ready = 1'b0;
    m_valid = 0; m_addr = '0; m_src = 0; m_flush = '0; m_acc = 0; m_drop = 0;
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_valid", 64'(redir_valid), 64'd0);
    chk("idle_cnts",  64'({accept_cnt, drop_cnt}), 64'd0);

    // single capture with fetch ready
    redir_ready = 1'b1;
    src_valid = 4'b0100; set_addr(2, 32'h1C00_0040);
    tick();
    chk("cap_valid", 64'(redir_valid), 64'd1);
    chk("cap_addr",  64'(redir_addr),  64'h1C00_0040);
    chk("cap_src",   64'(redir_src),   64'd2);
    chk("cap_flush", 64'(flush),       64'b1000);
    src_valid = '0;
    tick();
    chk("acc_valid", 64'(redir_valid), 64'd0);
    chk("acc_flush", 64'(flush),       64'd0);
    chk("acc_cnt",   64'(accept_cnt),  64'd1);

    // simultaneous requests, oldest wins
    redir_ready = 1'b0;
    src_valid = 4'b1011; set_addr(0, 32'h0000_1000); set_addr(1, 32'h0000_2000); set_addr(3, 32'h0000_3000);
    tick();
    chk("sim_src",   64'(redir_src),  64'd0);
    chk("sim_addr",  64'(redir_addr), 64'h1000);
    chk("sim_flush", 64'(flush),      64'b1110);
    chk("sim_drop",  64'(drop_cnt),   64'd2);
    src_valid = '0; redir_ready = 1'b1;
    tick();

    // replacement while stalled, then a younger request is dropped
    redir_ready = 1'b0;
    src_valid = 4'b0100; set_addr(2, 32'h0000_0200);
    tick();
    chk("hold_src", 64'(redir_src), 64'd2);
    src_valid = 4'b0010; set_addr(1, 32'h0000_0080);
    tick();
    chk("rep_src",   64'(redir_src),  64'd1);
    chk("rep_addr",  64'(redir_addr), 64'h80);
    chk("rep_flush", 64'(flush),      64'b1100);
    chk("rep_drop",  64'(drop_cnt),   64'd3);
    src_valid = 4'b1000; set_addr(3, 32'h0000_0999);
    tick();
    chk("yng_src",   64'(redir_src),  64'd1);
    chk("yng_addr",  64'(redir_addr), 64'h80);
    chk("yng_flush", 64'(flush),      64'd0);
    chk("yng_drop",  64'(drop_cnt),   64'd4);

    // back-to-back accept and capture
    redir_ready = 1'b1;
    src_valid = 4'b1000; set_addr(3, 32'h0000_0300);
    tick();
    chk("b2b_valid", 64'(redir_valid), 64'd1);
    chk("b2b_src",   64'(redir_src),   64'd3);
    chk("b2b_acc",   64'(accept_cnt),  64'd3);
    src_valid = '0;
    tick();
    chk("sat_acc16", 64'(accept_cnt), 64'd4);
    chk("sat_acc2",  64'(s_acc),      64'd3);
    src_valid = 4'b0001; set_addr(0, 32'h0000_0abc);
    tick();
    src_valid = '0;
    tick();
    chk("sat_acc2b", 64'(s_acc), 64'd3);

    // reset while a redirect is pending and fetch is ready
    redir_ready = 1'b0;
    src_valid = 4'b0001;
    tick();
    src_valid = '0; rst = 1'b1; redir_ready = 1'b1;
    tick();
    chk("rst_valid", 64'(redir_valid), 64'd0);
    chk("rst_acc",   64'(accept_cnt),  64'd0);
    chk("rst_drop",  64'(drop_cnt),    64'd0);
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      src_valid   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      redir_ready = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) set_addr(i, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_arb.md
Name: branch_redirect_arb

Overview:
Parametrised successor to the two-source branch/jump info bundle. It arbitrates NUM_SRC redirect requests by age priority, where index 0 is the oldest pipeline stage. The winning target is held in a register and presented to fetch over a valid/ready handshake. The block also issues a one-cycle flush mask to stages younger than the winner, and keeps saturating accept/drop statistics. It sits between the execute/commit-side redirect sources and the IF PC-select logic.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, redirect target width
NUM_SRC, 2, number of redirect sources (>=2); index 0 = highest priority (oldest)
CNT_WIDTH, 16, width of statistics counters
IDX_WIDTH, $clog2(NUM_SRC), source index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
src_valid  input  NUM_SRC  per-source redirect request, single-cycle pulse
src_addr  input  NUM_SRC*ADDR_WIDTH  per-source target; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
redir_valid  output  1  held redirect pending toward fetch
redir_addr  output  ADDR_WIDTH  held target
redir_src  output  IDX_WIDTH  index of held source
redir_ready  input  1  fetch accepts redirect this cycle
flush  output  NUM_SRC  one-cycle pulse; bit i set => flush stage i
accept_cnt  output  CNT_WIDTH  saturating count of accepted redirects
drop_cnt  output  CNT_WIDTH  saturating count of requests dropped as younger than the held one

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: redir_valid=0, redir_addr=0, redir_src=0, flush=0, accept_cnt=0, drop_cnt=0, FSM=IDLE.
- Reset wins over every same-cycle event. A pending redirect is discarded, not counted.
- Winner selection: the lowest index i with src_valid[i]=1. This is purely combinational from the inputs.
- Capture:
  - Next cycle: redir_valid=1, redir_addr=src_addr[w], redir_src=w, and flush bits (w+1..NUM_SRC-1)=1 for one cycle only.
  - Latency from request to redir_valid is 1 cycle.
  - Non-winning valid sources in the same cycle count toward drop_cnt. Add popcount-1, saturating.
- FSM IDLE:
  - any src_valid -> capture, go to PEND.
  - otherwise stay IDLE; flush=0.
- FSM PEND, redir_ready=1 (accept):
  - accept_cnt += 1, saturating at all-ones.
  - If any src_valid in the same cycle, capture the new winner (any index) and stay in PEND. redir_valid stays 1.
  - Otherwise go to IDLE; redir_valid=0 next cycle.
- FSM PEND, redir_ready=0:
  - If winner w < redir_src, replace: new addr/src, and flush pulse for w+1..NUM_SRC-1.
  - The replaced request counts toward drop_cnt, as do the other non-winners.
  - If w >= redir_src, all valid requests are dropped and counted. Held values are unchanged.
- Handshake rules:
  - redir_addr and redir_src are stable while redir_valid=1 and redir_ready=0, except on strict-priority replacement.
  - redir_ready is ignored while redir_valid=0.
- Saturation: both counters stop at 2^CNT_WIDTH-1 and never wrap.
- Simultaneous accept and drops in one cycle: both counters update independently.

Decomposition:
- Package branch_pkg:
  - ADDR_WIDTH import from width_param.
  - redirect FSM state enum {IDLE, PEND}.
  - Saturating-add helper function.
- Sub-module redirect_prio_enc: parameter NUM_SRC.
  - Inputs: valid vector.
  - Outputs: any, winner index, one-hot grant, popcount.
  - Fully combinational.
- The top level holds the FSM, target register, flush register and counters.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then all inputs 0 -> all outputs 0 for 10 cycles.
- Single capture, NUM_SRC=4, src_valid=4'b0100, addr[2]=0x1C000040, redir_ready=1 held:
  - next cycle: redir_valid=1, redir_addr=0x1C000040, redir_src=2, flush=4'b1000;
  - cycle after: redir_valid=0, flush=0, accept_cnt=1.
- Simultaneous requests, src_valid=4'b1011 -> redir_src=0, flush=4'b1110, drop_cnt=2.
- Priority replacement with redir_ready=0:
  - hold src 2, then pulse src 1 (addr 0x80) -> redir_src=1, addr=0x80, flush=4'b1100, drop_cnt+1;
  - then pulse src 3 -> held unchanged, drop_cnt+1.
- Back-to-back: accept in the same cycle as new src_valid[3] -> redir_valid stays 1, redir_src=3, accept_cnt+1.
- Saturation/reset mid-op:
  - CNT_WIDTH=2: 5 accepts -> accept_cnt=3.
  - Then rst during PEND -> redir_valid=0 and counters=0 next cycle, with no accept counted.
